// File: rtl/instr_fetch_unit_pkg.sv
// ============================================================================
// Module      : instr_fetch_unit_pkg
// Description : Fetch-state encoding and memory-map constants shared by the
//               fetch unit and the unified memory.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

package instr_fetch_unit_pkg;

    typedef enum logic [1:0] {
        ST_RUN   = 2'd0,
        ST_HALT  = 2'd1,
        ST_FAULT = 2'd2
    } fetch_state_t;

    localparam int unsigned INSTR_WIDTH      = 32;
    localparam int unsigned DATA_REGION_BASE = 100;
    localparam int unsigned DEF_TEXT_LIMIT   = DATA_REGION_BASE;
    localparam logic [INSTR_WIDTH-1:0] DEF_HALT_WORD = 32'hFFFF_FFFF;

endpackage

`default_nettype wire

// File: rtl/instr_fetch_unit_if.sv
// ============================================================================
// Module      : instr_fetch_unit_if
// Description : Fetch-stage bundle: decode control, memory read port and the
//               IF/ID outputs.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

interface instr_fetch_unit_if
    import instr_fetch_unit_pkg::*;
#(
    parameter int PC_WIDTH  = 32,
    parameter int CNT_WIDTH = 16
);
    logic                   Stall;
    logic                   BranchTaken;
    logic [PC_WIDTH-1:0]    BranchTarget;
    logic [PC_WIDTH-1:0]    ReadPC;
    logic [INSTR_WIDTH-1:0] Instruction;
    logic [INSTR_WIDTH-1:0] InstrOut;
    logic [PC_WIDTH-1:0]    PCOut;
    logic                   InstrValid;
    logic                   Halted;
    logic                   Fault;
    logic [CNT_WIDTH-1:0]   FetchCount;

    modport master (
        output Stall, BranchTaken, BranchTarget, Instruction,
        input  ReadPC, InstrOut, PCOut, InstrValid, Halted, Fault, FetchCount
    );

    modport slave (
        input  Stall, BranchTaken, BranchTarget, Instruction,
        output ReadPC, InstrOut, PCOut, InstrValid, Halted, Fault, FetchCount
    );
endinterface

`default_nettype wire

// File: rtl/instr_fetch_unit_ifid_reg.sv
// ============================================================================
// Module      : instr_fetch_unit_ifid_reg
// Description : IF/ID pipeline register; flush beats load beats invalidate.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module instr_fetch_unit_ifid_reg
    import instr_fetch_unit_pkg::*;
#(
    parameter int PC_WIDTH = 32
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   load,
    input  logic                   flush,
    input  logic                   invalidate,
    input  logic [INSTR_WIDTH-1:0] instr_d,
    input  logic [PC_WIDTH-1:0]    pc_d,
    output logic [INSTR_WIDTH-1:0] instr_q,
    output logic [PC_WIDTH-1:0]    pc_q,
    output logic                   valid_q
);
    logic [INSTR_WIDTH-1:0] r_instr;
    logic [PC_WIDTH-1:0]    r_pc;
    logic                   r_valid;

    // Flush zeroes the word but keeps the old address; invalidate keeps both.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_instr <= '0;
            r_pc    <= '0;
            r_valid <= 1'b0;
        end else if (flush) begin
            r_instr <= '0;
            r_valid <= 1'b0;
        end else if (load) begin
            r_instr <= instr_d;
            r_pc    <= pc_d;
            r_valid <= 1'b1;
        end else if (invalidate) begin
            r_valid <= 1'b0;
        end
    end

    assign instr_q = r_instr;
    assign pc_q    = r_pc;
    assign valid_q = r_valid;

endmodule

`default_nettype wire

// File: rtl/instr_fetch_unit.sv
// ============================================================================
// Module      : instr_fetch_unit
// Description : Fetch stage: PC, RUN/HALT/FAULT control, IF/ID register and a
//               saturating delivered-instruction counter.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module instr_fetch_unit
    import instr_fetch_unit_pkg::*;
#(
    parameter int                     PC_WIDTH   = 32,
    parameter logic [PC_WIDTH-1:0]    RESET_PC   = '0,
    parameter logic [PC_WIDTH-1:0]    TEXT_LIMIT = PC_WIDTH'(DEF_TEXT_LIMIT),
    parameter logic [INSTR_WIDTH-1:0] HALT_WORD  = DEF_HALT_WORD,
    parameter int                     CNT_WIDTH  = 16
) (
    input  logic              clk,
    input  logic              rst,
    instr_fetch_unit_if.slave bus
);
    localparam logic [CNT_WIDTH-1:0] CNT_MAX = {CNT_WIDTH{1'b1}};

    fetch_state_t           r_state, w_state_nxt;
    logic [PC_WIDTH-1:0]    r_pc, w_pc_nxt;
    logic [CNT_WIDTH-1:0]   r_count, w_count_nxt;
    logic                   w_load, w_flush, w_invalidate;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= ST_RUN;
            r_pc    <= RESET_PC;
            r_count <= '0;
        end else begin
            r_state <= w_state_nxt;
            r_pc    <= w_pc_nxt;
            r_count <= w_count_nxt;
        end
    end

    always_comb begin
        w_state_nxt  = r_state;
        w_pc_nxt     = r_pc;
        w_count_nxt  = r_count;
        w_load       = 1'b0;
        w_flush      = 1'b0;
        w_invalidate = 1'b0;
        case (r_state)
            ST_RUN: begin
                if (bus.BranchTaken) begin
                    // Wrong-path flush wins even over a stall or a halt word.
                    w_pc_nxt = bus.BranchTarget;
                    w_flush  = 1'b1;
                end else if (bus.Stall) begin
                    w_pc_nxt = r_pc;
                end else if (r_pc >= TEXT_LIMIT) begin
                    w_state_nxt  = ST_FAULT;
                    w_invalidate = 1'b1;
                end else begin
                    w_load      = 1'b1;
                    w_count_nxt = (r_count == CNT_MAX) ? r_count
                                                       : r_count + CNT_WIDTH'(1);
                    if (bus.Instruction == HALT_WORD) begin
                        w_state_nxt = ST_HALT;
                    end else begin
                        w_pc_nxt = r_pc + PC_WIDTH'(1);
                    end
                end
            end
            default: begin
                w_invalidate = 1'b1;
            end
        endcase
    end

    instr_fetch_unit_ifid_reg #(
        .PC_WIDTH (PC_WIDTH)
    ) u_ifid (
        .clk        (clk),
        .rst        (rst),
        .load       (w_load),
        .flush      (w_flush),
        .invalidate (w_invalidate),
        .instr_d    (bus.Instruction),
        .pc_d       (r_pc),
        .instr_q    (bus.InstrOut),
        .pc_q       (bus.PCOut),
        .valid_q    (bus.InstrValid)
    );

    assign bus.ReadPC     = r_pc;
    assign bus.Halted     = (r_state == ST_HALT);
    assign bus.Fault      = (r_state == ST_FAULT);
    assign bus.FetchCount = r_count;

endmodule

`default_nettype wire

// File: tb/tb_instr_fetch_unit.sv
// ============================================================================
// Module      : tb_instr_fetch_unit
// Description : Directed plus randomized bench against a behavioural model.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_instr_fetch_unit;
    import instr_fetch_unit_pkg::*;

    localparam int PCW    = 32;
    localparam int CW     = 4;
    localparam int CNTMAX = (1 << CW) - 1;
    localparam logic [31:0] HW = 32'hFFFF_FFFF;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    instr_fetch_unit_if #(.PC_WIDTH(PCW), .CNT_WIDTH(CW)) bus();

    instr_fetch_unit #(
        .PC_WIDTH   (PCW),
        .RESET_PC   (32'd0),
        .TEXT_LIMIT (32'd100),
        .HALT_WORD  (HW),
        .CNT_WIDTH  (CW)
    ) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    logic [31:0] mem [0:255];

    always_comb bus.Instruction = (bus.ReadPC < 32'd256) ? mem[bus.ReadPC[7:0]]
                                                         : (32'hDEAD_0000 ^ bus.ReadPC);

    function automatic logic [31:0] mem_word(input logic [31:0] a);
        return (a < 32'd256) ? mem[a[7:0]] : (32'hDEAD_0000 ^ a);
    endfunction

    // Behavioural model of the architectural state.
    logic [31:0] m_pc, m_instr, m_pcout;
    logic        m_valid, m_halted, m_faulted, m_known;
    int          m_count;
    int          n_vec  = 0;
    int          n_fail = 0;

    task automatic cmp(input string name, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, want %0h at %0t", name, got, exp, $time);
        end
    endtask

    always @(negedge clk) begin
        if (m_known) begin
            cmp("ReadPC",     bus.ReadPC,            m_pc);
            cmp("InstrOut",   bus.InstrOut,          m_instr);
            cmp("PCOut",      bus.PCOut,             m_pcout);
            cmp("InstrValid", 32'(bus.InstrValid),   32'(m_valid));
            cmp("Halted",     32'(bus.Halted),       32'(m_halted));
            cmp("Fault",      32'(bus.Fault),        32'(m_faulted));
            cmp("FetchCount", 32'(bus.FetchCount),   32'(m_count));
        end
    end

    // Advance model and DUT by one clock with the currently driven inputs.
    task automatic tick();
        logic [31:0] w, pc, ins, pco;
        logic        v, h, f;
        int          c;
        w = mem_word(m_pc);
        pc = m_pc; ins = m_instr; pco = m_pcout; v = m_valid;
        h = m_halted; f = m_faulted; c = m_count;
        if (rst) begin
            pc = 0; ins = 0; pco = 0; v = 0; h = 0; f = 0; c = 0;
        end else if (h || f) begin
            v = 0;
        end else if (bus.BranchTaken) begin
            pc = bus.BranchTarget; v = 0; ins = 0;
        end else if (bus.Stall) begin
            pc = m_pc;
        end else if (m_pc >= 32'd100) begin
            f = 1; v = 0;
        end else begin
            ins = w; pco = m_pc; v = 1;
            if (c < CNTMAX) c++;
            if (w == HW) h = 1;
            else pc = m_pc + 32'd1;
        end
        @(posedge clk);
        m_pc = pc; m_instr = ins; m_pcout = pco; m_valid = v;
        m_halted = h; m_faulted = f; m_count = c;
        if (rst) m_known = 1'b1;
        #1;
    endtask

    task automatic drive(input logic s, input logic b, input logic [31:0] t);
        bus.Stall = s; bus.BranchTaken = b; bus.BranchTarget = t;
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: got timeout, want finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        int stuck;
        m_known = 1'b0;
        m_pc = 0; m_instr = 0; m_pcout = 0; m_valid = 0;
        m_halted = 0; m_faulted = 0; m_count = 0;
        for (int i = 0; i < 256; i++) mem[i] = 32'(i) * 32'h0101 + 32'h1000;
        mem[0] = 32'h11; mem[1] = 32'h22; mem[2] = 32'h33; mem[3] = 32'h44;
        mem[4] = 32'h55; mem[5] = HW;     mem[10] = 32'hA0;
        rst = 1'b1;
        drive(0, 0, 0);

        tick();
        cmp("rst_ReadPC", bus.ReadPC, 32'd0);
        cmp("rst_Valid", 32'(bus.InstrValid), 32'd0);
        cmp("rst_InstrOut", bus.InstrOut, 32'd0);
        cmp("rst_Count", 32'(bus.FetchCount), 32'd0);
        cmp("rst_Flags", {30'd0, bus.Halted, bus.Fault}, 32'd0);
        rst = 1'b0;

        tick();
        cmp("seq0_Instr", bus.InstrOut, 32'h11);
        cmp("seq0_PCOut", bus.PCOut, 32'd0);
        tick();
        cmp("seq1_Instr", bus.InstrOut, 32'h22);
        cmp("seq1_ReadPC", bus.ReadPC, 32'd2);

        drive(1, 0, 0);
        repeat (3) tick();
        cmp("stall_ReadPC", bus.ReadPC, 32'd2);
        cmp("stall_Instr", bus.InstrOut, 32'h22);
        cmp("stall_PCOut", bus.PCOut, 32'd1);
        cmp("stall_Count", 32'(bus.FetchCount), 32'd2);
        drive(0, 0, 0);
        tick();
        cmp("resume_Instr", bus.InstrOut, 32'h33);
        cmp("resume_PCOut", bus.PCOut, 32'd2);

        drive(1, 1, 32'd10);
        tick();
        cmp("coll_ReadPC", bus.ReadPC, 32'd10);
        cmp("coll_Valid", 32'(bus.InstrValid), 32'd0);
        cmp("coll_Instr", bus.InstrOut, 32'd0);
        drive(0, 0, 0);
        tick();
        cmp("coll_PCOut", bus.PCOut, 32'd10);
        cmp("coll_Valid2", 32'(bus.InstrValid), 32'd1);
        cmp("coll_Instr2", bus.InstrOut, 32'hA0);

        drive(0, 1, 32'd4);
        tick();
        drive(0, 0, 0);
        tick();
        cmp("pre_halt_Instr", bus.InstrOut, 32'h55);
        tick();
        cmp("halt_PCOut", bus.PCOut, 32'd5);
        cmp("halt_Instr", bus.InstrOut, HW);
        cmp("halt_Valid", 32'(bus.InstrValid), 32'd1);
        cmp("halt_Halted", 32'(bus.Halted), 32'd1);
        cmp("halt_Count", 32'(bus.FetchCount), 32'd6);
        drive(1, 1, 32'd0);
        tick();
        cmp("halt_Valid2", 32'(bus.InstrValid), 32'd0);
        cmp("halt_ReadPC", bus.ReadPC, 32'd5);
        drive(0, 0, 0);

        rst = 1'b1; tick(); rst = 1'b0;
        drive(0, 1, 32'd100);
        tick();
        drive(0, 0, 0);
        tick();
        cmp("fault_Fault", 32'(bus.Fault), 32'd1);
        cmp("fault_Valid", 32'(bus.InstrValid), 32'd0);
        cmp("fault_ReadPC", bus.ReadPC, 32'd100);
        cmp("fault_Halted", 32'(bus.Halted), 32'd0);
        rst = 1'b1; tick(); rst = 1'b0;
        cmp("clr_ReadPC", bus.ReadPC, 32'd0);
        cmp("clr_Fault", 32'(bus.Fault), 32'd0);

        tick(); tick();
        drive(0, 1, 32'd7);
        tick();
        cmp("mid_ReadPC", bus.ReadPC, 32'd7);
        rst = 1'b1; drive(1, 1, 32'd20);
        tick();
        rst = 1'b0; drive(0, 0, 0);
        cmp("mid_ReadPC0", bus.ReadPC, 32'd0);
        cmp("mid_Valid", 32'(bus.InstrValid), 32'd0);
        cmp("mid_Count", 32'(bus.FetchCount), 32'd0);

        drive(0, 1, 32'd20);
        tick();
        drive(0, 0, 0);
        repeat (18) tick();
        cmp("sat_Count", 32'(bus.FetchCount), 32'(CNTMAX));
        cmp("sat_PCOut", bus.PCOut, 32'd37);

        for (int i = 0; i < 256; i++)
            mem[i] = ($urandom_range(19) == 0) ? HW : $urandom;
        stuck = 0;
        for (int n = 0; n < 3000; n++) begin
            stuck = (m_halted || m_faulted) ? stuck + 1 : 0;
            rst = ($urandom_range(59) == 0) || (stuck > 6);
            drive($urandom_range(3) == 0, $urandom_range(7) == 0,
                  ($urandom_range(7) == 0) ? 32'd100 + $urandom_range(29)
                                           : 32'($urandom_range(99)));
            tick();
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
        $finish;
    end

endmodule

`default_nettype wire
